// File: rtl/ransac_fixed_pkg.sv
// Shared fixed-point operand type and its saturation bounds.
package ransac_fixed;

  localparam int FIXED_W = 16;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = 16'sh7fff;
  localparam fixed_t FIXED_MIN = 16'sh8000;

endpackage

// File: rtl/fp_sat_add_sub.sv
// Saturating fixed_t add/subtract; clamped flags any overflow.
module fp_sat_add_sub
  import ransac_fixed::*;
(
  input  fixed_t lhs,
  input  fixed_t rhs,
  input  logic   subtract,
  output fixed_t res,
  output logic   clamped
);

  logic signed [FIXED_W:0] lhs_w;
  logic signed [FIXED_W:0] rhs_w;
  logic signed [FIXED_W:0] wide;

  assign lhs_w = {lhs[FIXED_W-1], lhs};
  assign rhs_w = {rhs[FIXED_W-1], rhs};

  always_comb begin
    wide    = subtract ? lhs_w - rhs_w : lhs_w + rhs_w;
    clamped = wide[FIXED_W] != wide[FIXED_W-1];
    res     = wide[FIXED_W-1:0];
    // Sign of the wide result picks the rail.
    unique case (1'b1)
      clamped && wide[FIXED_W]:  res = FIXED_MIN;
      clamped && !wide[FIXED_W]: res = FIXED_MAX;
      default:                   res = wide[FIXED_W-1:0];
    endcase
  end

endmodule

// File: rtl/fp_accumulator.sv
// Saturating accumulator: sums beats until last/max_count, then holds result.
module fp_accumulator
  import ransac_fixed::*;
#(
  parameter type         external_pipeline = logic,
  parameter int unsigned max_count         = 16
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  fixed_t           in_value,
  input  logic             in_subtract,
  input  logic             in_last,
  input  external_pipeline pipeline_i,
  output logic             out_valid,
  input  logic             out_ready,
  output fixed_t           out_sum,
  output logic [15:0]      out_count,
  output logic             out_saturated,
  output external_pipeline pipeline_o
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [15:0] MAX_CNT = 16'(max_count);

  state_t           state;
  fixed_t           acc;
  fixed_t           acc_nxt;
  logic [15:0]      count;
  logic [15:0]      count_nxt;
  logic             sat;
  logic             clamp;
  logic             accept;
  logic             close;
  external_pipeline pipe;

  fp_sat_add_sub u_sat (
    .lhs      (acc),
    .rhs      (in_value),
    .subtract (in_subtract),
    .res      (acc_nxt),
    .clamped  (clamp)
  );

  assign in_ready      = state == ACCUM;
  assign out_valid     = state == DONE;
  assign out_sum       = acc;
  assign out_count     = count;
  assign out_saturated = sat;
  assign pipeline_o    = pipe;

  assign count_nxt = count + 16'd1;
  assign accept    = in_valid && in_ready;
  assign close     = in_last || (count_nxt == MAX_CNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
      pipe  <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            sat   <= sat | clamp;
            pipe  <= pipeline_i;
            if (close) state <= DONE;
          end
        end
        DONE: begin
          // Sideband stays until the next accepted beat overwrites it.
          if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
